// File: rtl/complex_mult_pipe.sv
// Pipelined fixed-point complex multiplier: C = A*B or A*conj(B), rounded half-up and saturated.
// Three register stages share a single advance enable, which gives full valid/ready backpressure.
module complex_mult_pipe #(
  parameter int unsigned HALF_SIZE = 37,
  parameter int unsigned FRAC_BITS = 32,
  parameter int unsigned CPX_SIZE  = 2 * HALF_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready_in,
  input  logic [CPX_SIZE-1:0] cpx_A,
  input  logic [CPX_SIZE-1:0] cpx_B,
  input  logic                i_conj,
  output logic                o_valid,
  input  logic                i_ready_out,
  output logic [CPX_SIZE-1:0] cpx_C,
  output logic                o_ovf,
  input  logic                i_ovf_clr
);

  localparam int unsigned H  = HALF_SIZE;
  localparam int unsigned PW = 2 * H + 1;
  localparam int unsigned SW = PW + 1;

  localparam logic signed [SW-1:0] Rnd    = SW'(1) << (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] SatMax = (SW'(1) << (H - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SatMin = ~SatMax;

  logic                 v1_q, v2_q, v3_q;
  logic signed [H-1:0]  ar_q, ai_q, br_q;
  logic signed [H:0]    bi_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic [CPX_SIZE-1:0]  c_q;
  logic                 ovf_q, ovf_d;
  logic                 adv;

  assign adv        = !v3_q || i_ready_out;
  assign o_ready_in = adv;
  assign o_valid    = v3_q;
  assign cpx_C      = c_q;
  assign o_ovf      = ovf_q;

  // B.imag is widened by one bit before negation so that -(-2^(H-1)) is representable.
  logic signed [H:0] bi_d;
  always_comb begin
    bi_d = {cpx_B[H-1], cpx_B[H-1:0]};
    if (i_conj) begin
      bi_d = -bi_d;
    end
  end

  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  assign ar_x = {{(PW - H){ar_q[H-1]}}, ar_q};
  assign ai_x = {{(PW - H){ai_q[H-1]}}, ai_q};
  assign br_x = {{(PW - H){br_q[H-1]}}, br_q};
  assign bi_x = {{(PW - H - 1){bi_q[H]}}, bi_q};

  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  assign p_rr_d = ar_x * br_x;
  assign p_ii_d = ai_x * bi_x;
  assign p_ri_d = ar_x * bi_x;
  assign p_ir_d = ai_x * br_x;

  // One guard bit above the product width absorbs the sum before rounding.
  logic signed [SW-1:0] re_s, im_s, re_r, im_r;
  logic                 sat_re, sat_im;
  logic [H-1:0]         re_o, im_o;
  always_comb begin
    re_s   = {p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q} + Rnd;
    im_s   = {p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q} + Rnd;
    re_r   = re_s >>> FRAC_BITS;
    im_r   = im_s >>> FRAC_BITS;
    sat_re = (re_r > SatMax) || (re_r < SatMin);
    sat_im = (im_r > SatMax) || (im_r < SatMin);
    re_o   = (re_r > SatMax) ? SatMax[H-1:0] : (re_r < SatMin) ? SatMin[H-1:0] : re_r[H-1:0];
    im_o   = (im_r > SatMax) ? SatMax[H-1:0] : (im_r < SatMin) ? SatMin[H-1:0] : im_r[H-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
      c_q    <= '0;
    end else if (adv) begin
      v1_q <= i_valid;
      if (i_valid) begin
        ar_q <= cpx_A[CPX_SIZE-1:H];
        ai_q <= cpx_A[H-1:0];
        br_q <= cpx_B[CPX_SIZE-1:H];
        bi_q <= bi_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        p_rr_q <= p_rr_d;
        p_ii_q <= p_ii_d;
        p_ri_q <= p_ri_d;
        p_ir_q <= p_ir_d;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        c_q <= {re_o, im_o};
      end
    end
  end

  // A saturating result registering in the same cycle as a clear keeps the flag set.
  assign ovf_d = (ovf_q && !i_ovf_clr) || (adv && v2_q && (sat_re || sat_im));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe at HALF_SIZE=16, FRAC_BITS=14: directed vectors plus a
// scoreboard fed by an integer-arithmetic model, checked on every output transfer.
module tb_complex_mult_pipe;

  localparam int unsigned H = 16;
  localparam int unsigned F = 14;
  localparam int unsigned W = 2 * H;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, o_ready_in, i_conj, o_valid, i_ready_out, o_ovf, i_ovf_clr;
  logic [W-1:0] cpx_A, cpx_B, cpx_C;

  int           checks = 0;
  int           errors = 0;
  int           out_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_c = '0;

  always #5 clk = ~clk;

  complex_mult_pipe #(
    .HALF_SIZE(H),
    .FRAC_BITS(F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready_in (o_ready_in),
    .cpx_A      (cpx_A),
    .cpx_B      (cpx_B),
    .i_conj     (i_conj),
    .o_valid    (o_valid),
    .i_ready_out(i_ready_out),
    .cpx_C      (cpx_C),
    .o_ovf      (o_ovf),
    .i_ovf_clr  (i_ovf_clr)
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic longint rnd_sat(input longint v);
    longint q, mx, mn;
    mx = (longint'(1) << (H - 1)) - 1;
    mn = -(longint'(1) << (H - 1));
    q  = (v + (longint'(1) << (F - 1))) >>> F;
    if (q > mx) q = mx;
    if (q < mn) q = mn;
    return q;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic conj);
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(a[W-1:H]));
    ai = longint'($signed(a[H-1:0]));
    br = longint'($signed(b[W-1:H]));
    bi = longint'($signed(b[H-1:0]));
    if (conj) bi = -bi;
    re = rnd_sat(ar * br - ai * bi);
    im = rnd_sat(ar * bi + ai * br);
    return {re[H-1:0], im[H-1:0]};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      check("ready_rule", {31'b0, o_ready_in}, {31'b0, (!o_valid || i_ready_out)});
      if (hold_pend) begin
        check("hold_valid", {31'b0, o_valid}, 1);
        check("hold_data", cpx_C, hold_c);
      end
      hold_pend = o_valid && !i_ready_out;
      hold_c    = cpx_C;
      if (o_valid && i_ready_out) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'b0, o_valid}, 0);
        end else begin
          check("stream_data", cpx_C, exp_q.pop_front());
        end
      end
      if (i_valid && o_ready_in) exp_q.push_back(model(cpx_A, cpx_B, i_conj));
    end
  end

  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic conj, input logic clr_on_out, input logic [W-1:0] exp_c,
                         input logic exp_ovf);
    @(posedge clk); #1;
    i_valid = 1'b1; cpx_A = a; cpx_B = b; i_conj = conj;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check({nm, "_lat1"}, {31'b0, o_valid}, 0);
    @(posedge clk); #1;
    check({nm, "_lat2"}, {31'b0, o_valid}, 0);
    i_ovf_clr = clr_on_out;
    @(posedge clk); #1;
    i_ovf_clr = 1'b0;
    check({nm, "_valid"}, {31'b0, o_valid}, 1);
    check({nm, "_data"}, cpx_C, exp_c);
    check({nm, "_ovf"}, {31'b0, o_ovf}, {31'b0, exp_ovf});
    @(posedge clk); #1;
  endtask

  task automatic clear_ovf();
    i_ovf_clr = 1'b1;
    @(posedge clk); #1;
    i_ovf_clr = 1'b0;
    check("ovf_clear", {31'b0, o_ovf}, 0);
  endtask

  initial begin
    int sent, guard;
    logic acc;
    int base;
    rst = 1'b1;
    i_valid = 1'b0; cpx_A = '0; cpx_B = '0; i_conj = 1'b0;
    i_ready_out = 1'b1; i_ovf_clr = 1'b0;
    #1;
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_data", cpx_C, 0);
    check("rst_ovf", {31'b0, o_ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic products, with and without conjugation.
    run_one("mul", 32'h2000_2000, 32'h2000_2000, 1'b0, 1'b0, 32'h0000_2000, 1'b0);
    run_one("mulc", 32'h2000_2000, 32'h2000_2000, 1'b1, 1'b0, 32'h2000_0000, 1'b0);

    // Round half-up on the real part.
    run_one("rnd_p1", 32'h0001_0000, 32'h2000_0000, 1'b0, 1'b0, 32'h0001_0000, 1'b0);
    run_one("rnd_m1", 32'hFFFF_0000, 32'h2000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    run_one("rnd_p3", 32'h0003_0000, 32'h2000_0000, 1'b0, 1'b0, 32'h0002_0000, 1'b0);

    // Saturation and sticky overflow.
    run_one("sat_im", 32'h4000_4000, 32'h4000_4000, 1'b0, 1'b0, 32'h0000_7FFF, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      check("ovf_sticky", {31'b0, o_ovf}, 1);
    end
    clear_ovf();
    run_one("sat_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_0000, 1'b1);
    clear_ovf();
    run_one("neg_min", 32'h0000_8000, 32'h0000_8000, 1'b1, 1'b0, 32'h7FFF_0000, 1'b1);
    clear_ovf();

    // Clear coinciding with a saturating result: set wins.
    run_one("set_wins", 32'h4000_4000, 32'h4000_4000, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1);

    // Reset with two samples in flight.
    @(posedge clk); #1;
    i_valid = 1'b1; cpx_A = 32'h4000_4000; cpx_B = 32'h2000_2000; i_conj = 1'b0;
    @(posedge clk); #1;
    cpx_A = 32'h1000_0000;
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, o_valid}, 0);
    check("mid_rst_data", cpx_C, 0);
    check("mid_rst_ovf", {31'b0, o_ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_quiet", {31'b0, o_valid}, 0);
    end
    run_one("post_rst", 32'h2000_2000, 32'h2000_2000, 1'b0, 1'b0, 32'h0000_2000, 1'b0);

    // Random stream with random downstream backpressure.
    base  = out_cnt;
    sent  = 0;
    guard = 0;
    i_valid = 1'b1; cpx_A = $urandom; cpx_B = $urandom; i_conj = 1'($urandom_range(0, 1));
    while (sent < 10 && guard < 500) begin
      @(negedge clk);
      acc = o_ready_in;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        if (sent == 10) begin
          i_valid = 1'b0;
        end else begin
          cpx_A = $urandom; cpx_B = $urandom; i_conj = 1'($urandom_range(0, 1));
        end
      end
      i_ready_out = 1'($urandom_range(0, 1));
    end
    i_valid = 1'b0;
    check("stream_sent", sent, 10);
    i_ready_out = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", exp_q.size(), 0);
    check("stream_count", out_cnt - base, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
